// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and drives a 1-cycle-latency synchronous instruction memory.
// It hands each fetched word to decode over valid/ready, follows jumps, and stops after HALT.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 8,
  parameter int              INSTR_W  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = 4'b1111
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [3:0]         ir_opcode,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    pc_inflight_q;
  logic [INSTR_W-1:0]   ir_instr_q;
  logic [ADDR_W-1:0]    ir_pc_q;
  logic                 ir_valid_q;
  logic                 halted_q;
  logic                 fetch;
  logic                 redirect_taken;
  logic                 is_halt_op;

  assign is_halt_op     = (ir_instr_q[INSTR_W-1 -: 4] == HALT_OP);
  assign redirect_taken = redirect && (state_q != S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ISSUE: state_d = redirect ? S_ISSUE : S_WAIT;
      S_WAIT:  state_d = redirect ? S_ISSUE : S_HOLD;
      S_HOLD: begin
        if (redirect) begin
          state_d = S_ISSUE;
        end else if (ir_ready) begin
          state_d = is_halt_op ? S_HALT : S_WAIT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_ISSUE;
    endcase
  end

  // A jump always wins over issuing a fetch, and nothing is fetched while reset is high.
  always_comb begin
    fetch = 1'b0;
    if (!reset && !redirect) begin
      unique case (state_q)
        S_ISSUE: fetch = 1'b1;
        S_HOLD:  fetch = ir_ready && !is_halt_op;
        default: fetch = 1'b0;
      endcase
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_taken) begin
      pc_d = redirect_pc;
    end else if (fetch) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      pc_inflight_q <= '0;
      ir_instr_q    <= '0;
      ir_pc_q       <= '0;
      ir_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (fetch) begin
        pc_inflight_q <= pc_q;
      end
      // Returning data is dropped if a jump lands in the same cycle.
      if (state_q == S_WAIT && !redirect) begin
        ir_instr_q <= imem_rdata;
        ir_pc_q    <= pc_inflight_q;
        ir_valid_q <= 1'b1;
      end else if (state_q == S_HOLD && (redirect || ir_ready)) begin
        ir_valid_q <= 1'b0;
        if (!redirect && is_halt_op) begin
          halted_q <= 1'b1;
        end
      end
    end
  end

  assign imem_en   = fetch;
  assign imem_addr = pc_q;
  assign ir_valid  = ir_valid_q;
  assign ir_instr  = ir_instr_q;
  assign ir_opcode = ir_instr_q[INSTR_W-1 -: 4];
  assign ir_pc     = ir_pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed latency/backpressure/jump/halt sequences, then random
// traffic checked by a scoreboard that predicts the program-order stream decode must accept.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       ir_ready = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;

  logic       imem_en, ir_valid, halted;
  logic [7:0] imem_addr, imem_rdata, ir_instr, ir_pc;
  logic [3:0] ir_opcode;

  logic       w_en, w_valid, w_halted;
  logic [7:0] w_addr, w_rdata, w_instr, w_pc;
  logic [3:0] w_opcode;

  logic [7:0] mem [256];

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00), .HALT_OP(4'hF)) dut (
    .clk(clk), .reset(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_opcode(ir_opcode),
    .ir_pc(ir_pc), .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'hFE), .HALT_OP(4'hF)) dut_wrap (
    .clk(clk), .reset(rst), .imem_en(w_en), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .ir_valid(w_valid), .ir_ready(1'b1), .ir_instr(w_instr), .ir_opcode(w_opcode),
    .ir_pc(w_pc), .redirect(1'b0), .redirect_pc(8'h00), .halted(w_halted)
  );

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
    if (w_en)    w_rdata    <= mem[w_addr];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: addresses decode should accept next, in program order from the last restart point.
  logic [7:0] exp_q [$];
  logic [7:0] model_next = 8'h00;
  bit         model_halted = 1'b0;
  int         accepted = 0;

  task automatic step(input logic r, input logic rdy, input logic rd, input logic [7:0] rpc);
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      model_next   = 8'h00;
      model_halted = 1'b0;
    end else if (redirect && !model_halted) begin
      exp_q.delete();
      model_next = redirect_pc;
    end
    rst         = r;
    ir_ready    = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    while (exp_q.size() < 4) begin
      exp_q.push_back(model_next);
      model_next = model_next + 8'h01;
    end
    #3;
  endtask

  initial begin
    bit         was_halted;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      was_halted = model_halted;
      if (!rst) begin
        chk("halted", halted, was_halted);
        if (was_halted) begin
          chk("halt_valid", ir_valid, 1'b0);
          chk("halt_en", imem_en, 1'b0);
        end else if (ir_valid) begin
          if (exp_q.size() == 0) begin
            chk("sb_nonempty", 0, 1);
          end else begin
            e = exp_q[0];
            chk("ir_pc", ir_pc, e);
            chk("ir_instr", ir_instr, mem[e]);
            chk("ir_opcode", ir_opcode, mem[e] >> 4);
            $display("[TB] present pc=%02h instr=%02h ready=%0b redirect=%0b", ir_pc, ir_instr, ir_ready, redirect);
            if (ir_ready) begin
              void'(exp_q.pop_front());
              accepted++;
              if (mem[e][7:4] == 4'hF && !redirect) model_halted = 1'b1;
            end
          end
        end
      end
    end
  end

  // Wrap instance: accepted addresses count up from FE modulo 256 after every reset.
  int w_n = 0;
  bit w_seen = 1'b0;
  initial begin
    logic [7:0] we;
    forever begin
      @(negedge clk);
      if (rst) begin
        w_n = 0;
      end else if (w_valid) begin
        we = 8'hFE + 8'(w_n);
        chk("wrap_pc", w_pc, we);
        w_n++;
        if (w_n == 4) w_seen = 1'b1;
      end
    end
  end

  // {ready, redirect, exp_valid, exp_en, exp_halted, exp_pc}
  logic [12:0] tbl [16];

  initial begin
    logic [12:0] t;
    logic [7:0]  a;
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom);
      if (a[7:4] == 4'hF) a[7] = 1'b0;
      mem[i] = a;
    end
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'hF0;
    tbl = '{13'h1200, 13'h1000, 13'h1600, 13'h0000, 13'h0401, 13'h0401, 13'h0401, 13'h0401,
            13'h0401, 13'h1601, 13'h1000, 13'h1602, 13'h1000, 13'h1403, 13'h1900, 13'h1100};

    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    // Fetch 11/22/33, backpressure on 22, halt on F0, redirect ignored while halted.
    for (int k = 0; k < 16; k++) begin
      t = tbl[k];
      step(0, t[12], t[11], 8'h40);
      chk($sformatf("seq%0d_valid", k), ir_valid, t[10]);
      chk($sformatf("seq%0d_en", k), imem_en, t[9]);
      chk($sformatf("seq%0d_halted", k), halted, t[8]);
      if (t[10]) begin
        chk($sformatf("seq%0d_pc", k), ir_pc, t[7:0]);
        chk($sformatf("seq%0d_instr", k), ir_instr, mem[t[7:0]]);
      end
      if (t[9]) chk($sformatf("seq%0d_addr", k), imem_addr, t[10] ? t[7:0] + 8'h01 : t[7:0]);
    end

    step(1, 1, 0, 8'h00);
    chk("rst_en", imem_en, 1'b0);
    step(0, 1, 0, 8'h00);
    chk("restart_valid", ir_valid, 1'b0);
    chk("restart_halted", halted, 1'b0);
    chk("restart_en", imem_en, 1'b1);
    chk("restart_addr", imem_addr, 8'h00);
    // Jump while the first word is in flight.
    step(0, 1, 1, 8'h40);
    chk("wait_redir_en", imem_en, 1'b0);
    step(0, 1, 0, 8'h00);
    chk("jump_en", imem_en, 1'b1);
    chk("jump_addr", imem_addr, 8'h40);
    chk("jump_valid", ir_valid, 1'b0);
    step(0, 1, 0, 8'h00);
    chk("jump_wait_valid", ir_valid, 1'b0);
    step(0, 0, 0, 8'h00);
    chk("jump_tgt_valid", ir_valid, 1'b1);
    chk("jump_tgt_pc", ir_pc, 8'h40);
    // Reset while holding a valid instruction.
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    chk("hold_rst_valid", ir_valid, 1'b0);
    chk("hold_rst_addr", imem_addr, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    chk("resume_valid", ir_valid, 1'b1);
    chk("resume_pc", ir_pc, 8'h00);

    // Random traffic; memory is changed only while reset is held.
    step(1, 0, 0, 8'h00);
    mem[3] = 8'h34; mem[8'h80] = 8'hF5; mem[8'hC0] = 8'hFA;
    step(1, 0, 0, 8'h00);
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6,
           $urandom_range(0, 7) == 0, 8'($urandom));
    end
    step(1, 0, 0, 8'h00);
    chk("accepted_min", accepted > 300, 1'b1);
    chk("wrap_seq_seen", w_seen, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
